mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//   Multi-cycle integer multiply/divide unit holding the HI/LO pair.
//   Operands come from the GPR file's two read ports (rs, rt), which sit directly upstream.
//   It executes mult/multu/div/divu iteratively, one bit per cycle.
//   The execute stage stalls on busy and reads the result through hi/lo for mfhi/mflo.
// PARAMETERS
//   WIDTH  32  operand width; HI and LO are each WIDTH bits; iteration count = WIDTH
// PORTS
//   clk           in   1      clock, all state updates on rising edge
//   reset         in   1      asynchronous, active-high reset
//   start         in   1      request an operation; sampled only in IDLE
//   op            in   2      00 mult, 01 multu, 10 div, 11 divu
//   op_a          in   WIDTH  rs operand (gpr_read_data1)
//   op_b          in   WIDTH  rt operand (gpr_read_data2)
//   hi_wr_en      in   1      mthi: HI <= wr_data
//   lo_wr_en      in   1      mtlo: LO <= wr_data
//   wr_data       in   WIDTH  data for mthi/mtlo
//   hi            out  WIDTH  HI register (mfhi source)
//   lo            out  WIDTH  LO register (mflo source)
//   busy          out  1      operation in flight; pipeline must stall mfhi/mflo/mult/div
//   done          out  1      one-cycle pulse: HI/LO hold the new result this cycle
//   div_by_zero   out  1      one-cycle pulse with done; divisor was zero
// BEHAVIOUR
//   Reset
//     - Asynchronous. Takes effect mid-operation too; the in-flight op is discarded.
//     - State = IDLE.
//     - hi = lo = 0; busy = done = div_by_zero = 0.
//   States
//     - IDLE -> RUN: start=1 and not (div with op_b==0).
//     - IDLE -> DONE: start=1, div/divu, op_b==0.
//     - RUN: WIDTH cycles, counted by a down-counter. RUN -> FIX when the count reaches 0.
//     - FIX -> IDLE: apply sign fix-up, write HI/LO.
//     - DONE -> IDLE.
//   Capture (edge E0, start seen in IDLE)
//     - Latch op and both operands.
//     - Signed ops: latch operand magnitudes, plus neg_q = a[MSB]^b[MSB] and neg_r = a[MSB].
//     - Unsigned ops: neg_q = neg_r = 0.
//   Multiply
//     - Shift-add over 2*WIDTH-bit accumulator, one multiplier bit per RUN cycle.
//     - Result {HI,LO} = product; negated (two's complement, 2*WIDTH bits) if neg_q.
//   Divide
//     - Restoring division, one quotient bit per RUN cycle.
//     - LO = quotient, negated if neg_q. HI = remainder, negated if neg_r.
//     - -2^(WIDTH-1) / -1 signed: LO = 0x80000000, HI = 0. No trap.
//   Timing
//     - Normal op: busy=1 for cycles E0+1 .. E0+WIDTH+1 (i.e. E0+33 for WIDTH=32).
//     - At edge E0+WIDTH+1 (leaving FIX): HI/LO update, done=1 for one cycle, busy=0.
//     - Divide by zero: busy=1 for one cycle only.
//     - Divide by zero, edge E0+1: done=1 and div_by_zero=1, HI/LO unchanged, busy=0.
//     - Back-to-back: start may be asserted in the cycle done is high; it is accepted then (state is IDLE).
//   Start while busy
//     - Ignored; no queueing.
//   mthi/mtlo
//     - Take effect at the next edge only when state==IDLE and no result is written that edge.
//     - While busy they are ignored.
//     - If start is accepted at the same IDLE edge: the move is applied, then overwritten at completion.
//   Outputs
//     - hi/lo are registered and change only at reset, completion, or a move.
//     - busy is a registered decode of state != IDLE; done and div_by_zero are registered.
// TESTING
//   1. multu 0xFFFFFFFF x 0xFFFFFFFF -> after 33 cycles done=1, HI=0xFFFFFFFE, LO=0x00000001.
//   2. mult -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high exactly 33 cycles.
//   3. div -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//      divu 100 / 7 -> LO=14, HI=2.
//   4. div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
//      div 5 / 0 -> done and div_by_zero at E0+1, HI/LO unchanged.
//   5. start pulsed mid-run, and mthi 0x1234 while busy -> both ignored; result of first op intact.
//      mtlo 0xABCD in IDLE -> lo=0xABCD next cycle.
//   6. reset asserted at cycle 10 of a div -> busy=0, hi=lo=0 immediately.
//      New divu 9 / 3 after release -> LO=3, HI=0.

Source files
------------

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative HI/LO multiply/divide unit (shift-add multiply,
//               restoring divide, one bit per cycle) with mthi/mtlo moves.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_wr_en,
  input  logic             lo_wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int c_CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                 r_op_div;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [WIDTH-1:0]     r_opnd;
  logic [2*WIDTH-1:0]   r_acc;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_dbz;

  // Operand magnitudes for capture; op[0]=0 selects the signed variants
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_zero_div;

  assign w_signed   = ~op[0];
  assign w_a_neg    = w_signed & op_a[WIDTH-1];
  assign w_b_neg    = w_signed & op_b[WIDTH-1];
  assign w_a_mag    = w_a_neg ? (~op_a + 1'b1) : op_a;
  assign w_b_mag    = w_b_neg ? (~op_b + 1'b1) : op_b;
  assign w_zero_div = op[1] & (op_b == '0);

  // Multiply step: conditional add into the upper half, then shift right
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;

  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

  // Divide step: upper half is the partial remainder, lower half shifts the
  // dividend out while quotient bits shift in
  logic [WIDTH:0]     w_trial;
  logic [WIDTH:0]     w_diff;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem_next;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_trial    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_trial - {1'b0, r_opnd};
  assign w_qbit     = w_trial[WIDTH] | ~w_diff[WIDTH];
  assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_div_next = {w_rem_next, r_acc[WIDTH-2:0], w_qbit};

  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_prod_fix = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quo_fix  = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_zero_div ? S_DONE : S_RUN;
      S_RUN:   if (r_cnt == '0) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (r_state == S_FIX) || (r_state == S_DONE);
      r_dbz  <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          // Moves land even when start is accepted; completion overwrites them
          if (hi_wr_en) r_hi <= wr_data;
          if (lo_wr_en) r_lo <= wr_data;
          if (start) begin
            r_op_div <= op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_cnt    <= c_CNT_W'(WIDTH - 1);
            if (op[1]) begin
              r_opnd <= w_b_mag;
              r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
            end else begin
              r_opnd <= w_a_mag;
              r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
            end
          end
        end
        S_RUN: begin
          r_acc <= r_op_div ? w_div_next : w_mul_next;
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          if (r_op_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign hi          = r_hi;
  assign lo          = r_lo;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Self-checking bench for mul_div_unit: vector table, directed
//               multi-cycle sequences and randomized ops vs. arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        hi_wr_en = 1'b0;
  logic        lo_wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] hi, lo;
  logic        busy, done, div_by_zero;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .hi_wr_en(hi_wr_en), .lo_wr_en(lo_wr_en), .wr_data(wr_data),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          dbz;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; HI/LO untouched on divide-by-zero
  task automatic model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                       output bit dbz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dbz = 1'b0;
    case (mop)
      2'b00: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      2'b10: if (b == 0) dbz = 1'b1;
             else begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      default: if (b == 0) dbz = 1'b1;
               else begin m_lo = a / b; m_hi = a % b; end
    endcase
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic issue(input logic [1:0] iop, input logic [31:0] a, input logic [31:0] b);
    op = iop; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int nb);
    lat = 0; nb = 0;
    while (!done && lat < 200) begin
      if (busy) nb++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input logic [1:0] iop, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    bit dbz;
    int lat, nb;
    model(iop, a, b, dbz);
    issue(iop, a, b);
    wait_done(lat, nb);
    chk({tag, " latency"}, 64'(lat), dbz ? 64'd1 : 64'd33);
    chk({tag, " busy_cycles"}, 64'(nb), dbz ? 64'd1 : 64'd33);
    chk({tag, " hi"}, 64'(hi), 64'(m_hi));
    chk({tag, " lo"}, 64'(lo), 64'(m_lo));
    chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(dbz));
    chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int lat, nb;
    bit dbz;

    vecs[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1] = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5] = '{2'b10, 32'd5,        32'd0,        32'h00000000, 32'h80000000, 1'b1};
    vecs[6] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[7] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[8] = '{2'b11, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset dbz", 64'(div_by_zero), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Vector table; consecutive entries also exercise start in the done cycle
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat, nb);
      chk($sformatf("vec%0d latency", i), 64'(lat), vecs[i].dbz ? 64'd1 : 64'd33);
      chk($sformatf("vec%0d busy_cycles", i), 64'(nb), vecs[i].dbz ? 64'd1 : 64'd33);
      chk($sformatf("vec%0d hi", i), 64'(hi), 64'(vecs[i].hi));
      chk($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].lo));
      chk($sformatf("vec%0d dbz", i), 64'(div_by_zero), 64'(vecs[i].dbz));
    end
    m_hi = hi;
    m_lo = lo;
    if (m_hi !== vecs[8].hi || m_lo !== vecs[8].lo) begin
      m_hi = vecs[8].hi;
      m_lo = vecs[8].lo;
    end

    // Start and mthi while busy are both ignored
    model(2'b00, 32'hFFFFFFFD, 32'd7, dbz);
    issue(2'b00, 32'hFFFFFFFD, 32'd7);
    repeat (5) @(negedge clk);
    op = 2'b11; op_a = 32'd50; op_b = 32'd0; start = 1'b1;
    hi_wr_en = 1'b1; wr_data = 32'h1234;
    @(negedge clk);
    start = 1'b0; hi_wr_en = 1'b0;
    wait_done(lat, nb);
    chk("midrun latency", 64'(lat + 6), 64'd33);
    chk("midrun hi", 64'(hi), 64'(m_hi));
    chk("midrun lo", 64'(lo), 64'(m_lo));
    chk("midrun dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    chk("midrun done_pulse", 64'(done), 64'd0);
    chk("midrun no_queue", 64'(busy), 64'd0);

    // Moves in IDLE
    lo_wr_en = 1'b1; hi_wr_en = 1'b1; wr_data = 32'hABCD;
    @(negedge clk);
    lo_wr_en = 1'b0; hi_wr_en = 1'b0;
    m_lo = 32'hABCD; m_hi = 32'hABCD;
    chk("mtlo lo", 64'(lo), 64'h ABCD);
    chk("mthi hi", 64'(hi), 64'hABCD);

    // Async reset mid-divide
    issue(2'b11, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid busy", 64'(busy), 64'd0);
    chk("rst_mid hi", 64'(hi), 64'd0);
    chk("rst_mid lo", 64'(lo), 64'd0);
    chk("rst_mid done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    do_op(2'b11, 32'd9, 32'd3, "post_rst divu");

    // Randomized ops
    for (int k = 0; k < 30; k++) begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      do_op(rop, ra, rb, $sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
